// File: rtl/bus_arbiter_param_pkg.sv
// Shared types for the parametrised serial-bus arbiter.
// State encodings and index-width helper.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    CONNECT = 3'd2,
    RELEASE = 3'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_param_if.sv
// Master and slave side signals of the serial-bus arbiter.
// Masters and slaves drive their own modports; the arbiter uses arb.
interface bus_arbiter_param_if #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3
);
  logic [NUM_MASTERS-1:0] m_request;
  logic [NUM_MASTERS-1:0] m_address;
  logic [NUM_MASTERS-1:0] m_data;
  logic [NUM_MASTERS-1:0] m_address_valid;
  logic [NUM_MASTERS-1:0] m_valid;
  logic [NUM_MASTERS-1:0] m_write_en;
  logic [NUM_MASTERS-1:0] m_burst;
  logic [NUM_MASTERS-1:0] m_data_out;
  logic [NUM_MASTERS-1:0] m_ready;
  logic [NUM_MASTERS-1:0] m_available;
  logic [NUM_MASTERS-1:0] m_valid_in;
  logic [NUM_SLAVES-1:0]  s_data_in;
  logic [NUM_SLAVES-1:0]  s_ready;
  logic [NUM_SLAVES-1:0]  s_valid_out;
  logic [NUM_SLAVES-1:0]  s_hold;
  logic [NUM_SLAVES-1:0]  s_address;
  logic [NUM_SLAVES-1:0]  s_data;
  logic [NUM_SLAVES-1:0]  s_write_en;
  logic [NUM_SLAVES-1:0]  s_burst;
  logic [NUM_SLAVES-1:0]  s_valid;
  logic [NUM_SLAVES-1:0]  bus_ready_s;

  modport master (
    output m_request, m_address, m_data,
    output m_address_valid, m_valid,
    output m_write_en, m_burst,
    input  m_data_out, m_ready,
    input  m_available, m_valid_in
  );

  modport slave (
    output s_data_in, s_ready,
    output s_valid_out, s_hold,
    input  s_address, s_data, s_write_en,
    input  s_burst, s_valid, bus_ready_s
  );

  modport arb (
    input  m_request, m_address, m_data,
    input  m_address_valid, m_valid,
    input  m_write_en, m_burst,
    output m_data_out, m_ready,
    output m_available, m_valid_in,
    input  s_data_in, s_ready,
    input  s_valid_out, s_hold,
    output s_address, s_data, s_write_en,
    output s_burst, s_valid, bus_ready_s
  );
endinterface

// File: rtl/bus_arbiter_param_rr_grant.sv
// Combinational winner pick: round-robin after ptr,
// or fixed priority with the lowest index winning.
module rr_grant
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int RR_MODE     = 1,
  parameter int IW          = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] win,
  output logic [IW-1:0]          win_idx,
  output logic                   any
);

  int j;

  // Scan farthest-first so the nearest requester is kept last
  always_comb begin
    win     = '0;
    win_idx = '0;
    j       = 0;
    any     = |req;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (RR_MODE != 0)
        j = (int'(ptr) + k) % NUM_MASTERS;
      else
        j = k - 1;
      if (req[j[IW-1:0]]) begin
        win     = NUM_MASTERS'(1) << j;
        win_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_param.sv
// N-master / M-slave bit-serial bus arbiter with
// serial slave select, hold-aware release and timeout.
module bus_arbiter_param
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3,
  parameter int SEL_BITS    = 2,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  bus_arbiter_param_if.arb       bus,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [2:0]             state,
  output logic                   decode_err,
  output logic                   timeout_err
);

  localparam int IW = idx_w(NUM_MASTERS);
  localparam int CW = idx_w(SEL_BITS + 1);
  localparam int NM = NUM_MASTERS;
  localparam int NS = NUM_SLAVES;

  state_t            st_q, st_d;
  logic [NM-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [SEL_BITS-1:0] sel_q, sel_d, sel_sh;
  logic [SEL_BITS:0] sel_ext;
  logic [CW-1:0]     bit_q, bit_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              derr_q, derr_d;
  logic              terr_q, terr_d;

  logic [NM-1:0] win;
  logic [IW-1:0] win_idx;
  logic          any_req;
  logic [NS-1:0] sel_oh;
  logic w_req, w_addr, w_data, w_av, w_mv, w_we, w_burst;
  logic s_din, s_rdy, s_vo, s_hld;
  logic last_bit, bad_sel, idle_cyc, to_hit;

  rr_grant #(
    .NUM_MASTERS(NM),
    .RR_MODE    (RR_MODE),
    .IW         (IW)
  ) u_pick (
    .req    (bus.m_request),
    .ptr    (ptr_q),
    .win    (win),
    .win_idx(win_idx),
    .any    (any_req)
  );

  // Winner and selected-slave views of the bus
  always_comb begin
    for (int s = 0; s < NS; s++)
      sel_oh[s] = (sel_q == SEL_BITS'(s));
    w_req    = |(bus.m_request & gnt_q);
    w_addr   = |(bus.m_address & gnt_q);
    w_data   = |(bus.m_data & gnt_q);
    w_av     = |(bus.m_address_valid & gnt_q);
    w_mv     = |(bus.m_valid & gnt_q);
    w_we     = |(bus.m_write_en & gnt_q);
    w_burst  = |(bus.m_burst & gnt_q);
    s_din    = |(bus.s_data_in & sel_oh);
    s_rdy    = |(bus.s_ready & sel_oh);
    s_vo     = |(bus.s_valid_out & sel_oh);
    s_hld    = |(bus.s_hold & sel_oh);
    sel_ext  = {sel_q, w_addr};
    sel_sh   = sel_ext[SEL_BITS-1:0];
    last_bit = (bit_q == CW'(SEL_BITS - 1));
    bad_sel  = int'(sel_sh) >= NS;
    idle_cyc = !w_av && !w_mv && !s_vo && !s_hld;
    to_hit   = (to_q == TO_W'(TIMEOUT - 1));
  end

  // Next-state, grant, select shift and timeout
  always_comb begin
    st_d   = st_q;
    gnt_d  = gnt_q;
    ptr_d  = ptr_q;
    sel_d  = sel_q;
    bit_d  = bit_q;
    to_d   = to_q;
    derr_d = 1'b0;
    terr_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (any_req) begin
          gnt_d = win;
          if (RR_MODE != 0) ptr_d = win_idx;
          sel_d = '0;
          bit_d = '0;
          to_d  = '0;
          st_d  = SELECT;
        end
      end
      SELECT: begin
        if (w_av && last_bit && bad_sel) begin
          derr_d = 1'b1;
          st_d   = IDLE;
        end else if (!w_req) begin
          st_d = IDLE;
        end else if (w_av && last_bit) begin
          sel_d = sel_sh;
          to_d  = '0;
          st_d  = CONNECT;
        end else if (w_av) begin
          sel_d = sel_sh;
          bit_d = bit_q + CW'(1);
          to_d  = '0;
        end else if (!idle_cyc) begin
          to_d = '0;
        end else if (to_hit) begin
          terr_d = 1'b1;
          st_d   = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      CONNECT: begin
        if (!w_req) begin
          to_d = '0;
          st_d = s_hld ? RELEASE : IDLE;
        end else if (!idle_cyc) begin
          to_d = '0;
        end else if (to_hit) begin
          terr_d = 1'b1;
          st_d   = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      RELEASE: begin
        if (!s_hld) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (st_d == IDLE && st_q != IDLE) begin
      gnt_d = '0;
      sel_d = '0;
      bit_d = '0;
      to_d  = '0;
    end
  end

  // State register; reset aborts any transfer at once
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q   <= IDLE;
      gnt_q  <= '0;
      ptr_q  <= IW'(NM - 1);
      sel_q  <= '0;
      bit_q  <= '0;
      to_q   <= '0;
      derr_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      ptr_q  <= ptr_d;
      sel_q  <= sel_d;
      bit_q  <= bit_d;
      to_q   <= to_d;
      derr_q <= derr_d;
      terr_q <= terr_d;
    end
  end

  // Routing between the owner and the selected slave
  always_comb begin
    bus.m_available = (st_q == IDLE) ? '1 : gnt_q;
    bus.m_data_out  = '0;
    bus.m_ready     = '0;
    bus.m_valid_in  = '0;
    bus.s_address   = '0;
    bus.s_data      = '0;
    bus.s_write_en  = '0;
    bus.s_burst     = '0;
    bus.s_valid     = '0;
    bus.bus_ready_s = '0;
    if (st_q == CONNECT) begin
      bus.s_address   = sel_oh & {NS{w_addr}};
      bus.s_data      = sel_oh & {NS{w_data}};
      bus.s_write_en  = sel_oh & {NS{w_we}};
      bus.s_burst     = sel_oh & {NS{w_burst}};
      bus.s_valid     = sel_oh & {NS{w_av | w_mv}};
      bus.bus_ready_s = sel_oh;
    end
    if (st_q == CONNECT || st_q == RELEASE) begin
      bus.m_data_out = gnt_q & {NM{s_din}};
      bus.m_ready    = gnt_q & {NM{s_rdy}};
      bus.m_valid_in = gnt_q & {NM{s_vo}};
    end
  end

  assign grant       = gnt_q;
  assign state       = st_q;
  assign decode_err  = derr_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter_param.sv
// Directed bench for bus_arbiter_param: vector table
// plus hand sequences for reset, RR order and timeout.
module tb_bus_arbiter_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_arbiter_param_if #(.NUM_MASTERS(4), .NUM_SLAVES(3)) b ();
  bus_arbiter_param_if #(.NUM_MASTERS(4), .NUM_SLAVES(3)) bf ();

  logic [3:0] grant, grant_f;
  logic [2:0] state, state_f;
  logic       derr, derr_f, terr, terr_f;

  assign bf.m_request       = b.m_request;
  assign bf.m_address       = b.m_address;
  assign bf.m_data          = b.m_data;
  assign bf.m_address_valid = b.m_address_valid;
  assign bf.m_valid         = b.m_valid;
  assign bf.m_write_en      = b.m_write_en;
  assign bf.m_burst         = b.m_burst;
  assign bf.s_data_in       = b.s_data_in;
  assign bf.s_ready         = b.s_ready;
  assign bf.s_valid_out     = b.s_valid_out;
  assign bf.s_hold          = b.s_hold;

  bus_arbiter_param #(
    .NUM_MASTERS(4), .NUM_SLAVES(3), .SEL_BITS(2),
    .RR_MODE(1), .TIMEOUT(255), .TO_W(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(b),
    .grant(grant), .state(state),
    .decode_err(derr), .timeout_err(terr)
  );

  bus_arbiter_param #(
    .NUM_MASTERS(4), .NUM_SLAVES(3), .SEL_BITS(2),
    .RR_MODE(0), .TIMEOUT(255), .TO_W(8)
  ) dut_fx (
    .clk(clk), .reset(reset), .bus(bf),
    .grant(grant_f), .state(state_f),
    .decode_err(derr_f), .timeout_err(terr_f)
  );

  typedef struct {
    logic [3:0] req, av, addr, mv, dat, we;
    logic [2:0] hold, svo;
    logic [2:0] st;
    logic [3:0] gr, mav;
    logic [2:0] sv, sa, sd, brs;
    logic [3:0] mvi;
    logic       derr;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(
    input int req, av, addr, mv, dat, we, hold, svo,
    input int st, gr, mav, sv, sa, sd, brs, mvi, de
  );
    vec_t v;
    v.req = 4'(req); v.av = 4'(av); v.addr = 4'(addr);
    v.mv = 4'(mv); v.dat = 4'(dat); v.we = 4'(we);
    v.hold = 3'(hold); v.svo = 3'(svo);
    v.st = 3'(st); v.gr = 4'(gr); v.mav = 4'(mav);
    v.sv = 3'(sv); v.sa = 3'(sa); v.sd = 3'(sd);
    v.brs = 3'(brs); v.mvi = 4'(mvi); v.derr = de[0];
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int req, av, addr, mv, dat, we,
                     input int hold, svo);
    b.m_request       = 4'(req);
    b.m_address_valid = 4'(av);
    b.m_address       = 4'(addr);
    b.m_valid         = 4'(mv);
    b.m_data          = 4'(dat);
    b.m_write_en      = 4'(we);
    b.s_hold          = 3'(hold);
    b.s_valid_out     = 3'(svo);
  endtask

  function automatic logic [63:0] all_out();
    return {21'd0, state, grant, b.m_available,
            b.s_address, b.s_data, b.s_write_en, b.s_burst,
            b.s_valid, b.bus_ready_s, b.m_data_out,
            b.m_ready, b.m_valid_in, derr, terr};
  endfunction

  logic [63:0] idle_out;

  initial begin
    idle_out = {21'd0, 3'd0, 4'd0, 4'hF, 32'd0};
    b.m_burst   = '0;
    b.s_ready   = '0;
    b.s_data_in = '0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    tick();
    #1;
    chk("reset_rr", all_out(), idle_out);
    chk("reset_fx", {state_f, grant_f, bf.m_available},
        {3'd0, 4'd0, 4'hF});
    reset = 1'b1;
    tick();

    // master 0 -> slave 2, write, drop with no hold
    vq.push_back(mk(1,0,0,0,0,0,0,0, 0,0,15,0,0,0,0,0,0));
    vq.push_back(mk(1,1,1,0,0,0,0,0, 1,1,1,0,0,0,0,0,0));
    vq.push_back(mk(1,1,0,0,0,0,0,0, 1,1,1,0,0,0,0,0,0));
    vq.push_back(mk(1,1,1,0,0,1,0,0, 2,1,1,4,4,0,4,0,0));
    vq.push_back(mk(1,0,0,1,1,0,0,0, 2,1,1,4,0,4,4,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,4, 2,1,1,0,0,0,4,1,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 2,1,1,0,0,0,4,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 0,0,15,0,0,0,0,0,0));
    // master 1 -> slave 1, drop under hold, 10 RELEASE cycles
    vq.push_back(mk(2,0,0,0,0,0,0,0, 0,0,15,0,0,0,0,0,0));
    vq.push_back(mk(2,2,0,0,0,0,0,0, 1,2,2,0,0,0,0,0,0));
    vq.push_back(mk(2,2,2,0,0,0,0,0, 1,2,2,0,0,0,0,0,0));
    vq.push_back(mk(2,0,0,0,0,0,2,0, 2,2,2,0,0,0,2,0,0));
    vq.push_back(mk(0,0,0,0,0,0,2,0, 2,2,2,0,0,0,2,0,0));
    for (int k = 0; k < 10; k++)
      vq.push_back(mk((k == 2) ? 2 : 0, 0,0,2,2,0,2,2,
                      3,2,2,0,0,0,0,2,0));
    vq.push_back(mk(0,0,0,0,0,0,0,2, 3,2,2,0,0,0,0,2,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 0,0,15,0,0,0,0,0,0));
    // master 2 selects slave 3: decode error
    vq.push_back(mk(4,0,0,0,0,0,0,0, 0,0,15,0,0,0,0,0,0));
    vq.push_back(mk(4,4,4,0,0,0,0,0, 1,4,4,0,0,0,0,0,0));
    vq.push_back(mk(4,4,4,0,0,0,0,0, 1,4,4,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 0,0,15,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 0,0,15,0,0,0,0,0,0));
    // master 3: bad select with same-cycle drop
    vq.push_back(mk(8,0,0,0,0,0,0,0, 0,0,15,0,0,0,0,0,0));
    vq.push_back(mk(8,8,8,0,0,0,0,0, 1,8,8,0,0,0,0,0,0));
    vq.push_back(mk(0,8,8,0,0,0,0,0, 1,8,8,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 0,0,15,0,0,0,0,0,1));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 0,0,15,0,0,0,0,0,0));

    foreach (vq[i]) begin
      drv(vq[i].req, vq[i].av, vq[i].addr, vq[i].mv,
          vq[i].dat, vq[i].we, vq[i].hold, vq[i].svo);
      #1;
      chk($sformatf("vec%0d", i),
          {36'd0, state, grant, b.m_available, b.s_valid,
           b.s_address, b.s_data, b.bus_ready_s,
           b.m_valid_in, derr},
          {36'd0, vq[i].st, vq[i].gr, vq[i].mav, vq[i].sv,
           vq[i].sa, vq[i].sd, vq[i].brs, vq[i].mvi,
           vq[i].derr});
      tick();
    end

    // round-robin vs fixed priority, all masters requesting
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int t = 0; t < 5; t++) begin
      drv(15, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drv(15, 15, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("rr_grant%0d", t), {60'd0, grant},
          {60'd0, 4'b0001 << (t % 4)});
      chk($sformatf("fx_grant%0d", t), {60'd0, grant_f},
          64'd1);
      tick();
      tick();
      drv(15, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end

    // stall in CONNECT, restart at cycle 200, fire at 255
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("to_connect", {61'd0, state}, 64'd2);
    repeat (199) tick();
    chk("to_199", {60'd0, state, terr}, {60'd0, 3'd2, 1'b0});
    drv(1, 0, 0, 1, 0, 0, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (254) tick();
    chk("to_254", {60'd0, state, terr}, {60'd0, 3'd2, 1'b0});
    tick();
    chk("to_fire", {60'd0, state, terr}, {60'd0, 3'd0, 1'b1});
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("to_pulse", {60'd0, state, terr}, {60'd0, 3'd0, 1'b0});

    // reset during CONNECT master 1 -> slave 0
    drv(2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drv(2, 2, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    drv(2, 0, 0, 2, 2, 2, 0, 0);
    #1;
    chk("rst_pre", {57'd0, state, grant, b.s_valid},
        {57'd0, 3'd2, 4'd2, 3'd1});
    reset = 1'b0;
    tick();
    chk("rst_mid", all_out(), idle_out);
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_param.md
Name: bus_arbiter_param

Overview:
Parametrised successor to the fixed 2-master/3-slave serial-bus arbiter. It arbitrates NUM_MASTERS bit-serial masters onto NUM_SLAVES slaves, with selectable round-robin or fixed-priority grant. The slave is decoded from the leading serial address bits, and a hold-aware release phase and an inactivity timeout are added. It sits between the master ports (emmaster, uart_to_bus, …) and the slave ports (slave, emslave, uart_tx_toplevel) at top level.

Parameters:
NUM_MASTERS, 4, number of master ports (2..8)
NUM_SLAVES, 3, number of slave ports (1..2**SEL_BITS)
SEL_BITS, 2, leading serial address bits that select the slave, sent MSB first
RR_MODE, 1, 1 = round-robin grant, 0 = fixed priority (lowest index wins)
TIMEOUT, 255, idle cycles allowed in SELECT/CONNECT before forced release
TO_W, 8, timeout counter width (must be ≥ clog2(TIMEOUT+1))

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
m_request  in  NUM_MASTERS  bus request per master
m_address  in  NUM_MASTERS  serial address bit per master
m_data  in  NUM_MASTERS  serial write-data bit per master
m_address_valid  in  NUM_MASTERS  address bit strobe
m_valid  in  NUM_MASTERS  data bit strobe
m_write_en  in  NUM_MASTERS  1 = write, 0 = read
m_burst  in  NUM_MASTERS  burst flag
s_data_in  in  NUM_SLAVES  serial read-data bit from slave
s_ready  in  NUM_SLAVES  slave ready
s_valid_out  in  NUM_SLAVES  slave read-data strobe
s_hold  in  NUM_SLAVES  slave requests the bus be kept
m_data_out  out  NUM_MASTERS  routed read data
m_ready  out  NUM_MASTERS  routed s_ready
m_available  out  NUM_MASTERS  bus available / granted
m_valid_in  out  NUM_MASTERS  routed s_valid_out
s_address, s_data, s_write_en, s_burst  out  NUM_SLAVES each  routed master signals
s_valid  out  NUM_SLAVES  m_address_valid | m_valid of the winner
bus_ready_s  out  NUM_SLAVES  connected-slave indication
grant  out  NUM_MASTERS  one-hot current owner
state  out  3  FSM state
decode_err  out  1  one-cycle pulse, bad slave index
timeout_err  out  1  one-cycle pulse, timeout release

Behaviour:
- All routing outputs are combinational from the registered state, grant and sel. Non-selected ports and non-granted masters are driven 0.
- Reset (reset=0 at posedge):
  - state ← IDLE, grant ← 0, sel ← 0, timeout counter ← 0, error pulses ← 0.
  - RR pointer ← NUM_MASTERS-1, so master 0 has first priority.
  - After reset: m_available all 1, every other output 0.
  - Reset mid-transaction aborts immediately; there is no drain.
- States: IDLE=0, SELECT=1, CONNECT=2, RELEASE=3.
- IDLE:
  - m_available = all 1.
  - If any m_request is high, the winner is chosen and grant is registered; next state is SELECT.
  - RR: first requester after the pointer, wrapping modulo NUM_MASTERS. The pointer updates to the winner on grant.
  - Fixed: lowest index wins.
  - There is always ≥ 1 IDLE cycle between owners.
- SELECT:
  - m_available = grant only.
  - Each cycle the winner's m_address_valid=1, one m_address bit is shifted into sel (MSB first).
  - After SEL_BITS bits:
    - If sel ≥ NUM_SLAVES: decode_err pulse, then IDLE.
    - Otherwise: CONNECT.
  - Select bits are not forwarded; the first forwarded address bit is bit SEL_BITS.
  - If the winner drops m_request: IDLE, no error.
- CONNECT:
  - Winner's signals are routed to slave sel; slave sel's signals are routed back to the winner.
  - bus_ready_s[sel] = 1.
  - When the winner drops m_request:
    - s_hold[sel]=0: IDLE next cycle.
    - Otherwise: RELEASE.
- RELEASE:
  - Slave → master routing is kept; master → slave signals are forced to 0.
  - Exit to IDLE on the first cycle s_hold[sel]=0.
  - Re-assertion of request in RELEASE is ignored.
- Timeout:
  - In SELECT and CONNECT the counter increments on each cycle where the winner's m_address_valid, m_valid and the selected s_valid_out are all 0, and s_hold[sel]=0. It clears otherwise.
  - At count == TIMEOUT-1: timeout_err pulse, then IDLE, counter cleared.
  - The counter never wraps. It is cleared on every state change.
  - RELEASE has no timeout.
- Simultaneous events:
  - Timeout and request-drop in the same cycle: drop wins, no error.
  - decode_err takes precedence over a same-cycle request-drop.

Decomposition:
- Package bus_arb_pkg holds:
  - state encodings (IDLE/SELECT/CONNECT/RELEASE)
  - width helpers (clog2-based index width for grant/sel)
- Sub-module rr_grant(NUM_MASTERS, RR_MODE): request vector + pointer → one-hot winner and index. This is pure combinational logic and is reused by future split-transaction arbiters.

Test Plan:
1. Reset held low during CONNECT (master 1 → slave 0) → next cycle state=0, grant=0000, m_available=1111, all s_* = 0.
2. Master 0 requests, sends select bits 1,0 then write address/data → grant=0001; state 0→1→1→2; s_valid[2] mirrors strobes from bit 2 onward; after request drop with hold=0, IDLE one cycle later.
3. RR_MODE=1, all four masters continuously requesting, each transaction 5 cycles → grant sequence 0001,0010,0100,1000,0001. With RR_MODE=0 → 0001 every time.
4. NUM_SLAVES=3, select bits 1,1 → decode_err=1 for one cycle, state=0, m_available=1111, no s_valid asserted.
5. Master stalls in CONNECT with no strobes and no hold → timeout_err on the 255th idle cycle, state=0. A strobe at cycle 200 restarts the count.
6. Master drops request while s_hold[1]=1 for 10 cycles → state=3 for 10 cycles, m_valid_in still routed; IDLE on the first cycle hold=0.
